imem_access_ctrl: RTL and testbench
===================================

# imem_access_ctrl

Sequencing and arbitration controller for the byte-organised, single-port instruction memory (`INSTRUCTION_LEN`-bit words, big-endian, four bytes per word, combinational read). It sits between the fetch stage, a program loader (boot/debug patch path) and the memory's address/WriteData/MemRead/MemWrite/ReadData port. It holds the core in a boot phase while the loader fills memory. After boot it shares the port between fetch reads and loader writes, with a bounded-starvation guarantee for the loader.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width (= `INSTRUCTION_LEN`)
- MAX_FETCH_RUN, 4, max consecutive fetch grants while a load is pending (1..15)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- load_valid  in  1  loader write request
- load_addr  in  ADDR_W  loader byte address
- load_data  in  DATA_W  loader word
- load_ready  out  1  loader write accepted this cycle
- load_done  in  1  single-cycle pulse: boot image complete
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_W  fetch byte address (PC)
- fetch_gnt  out  1  fetch read performed this cycle
- fetch_valid  out  1  fetch_data valid (cycle after fetch_gnt)
- fetch_data  out  DATA_W  registered instruction word
- cpu_hold  out  1  stall core (boot phase)
- err_misaligned  out  1  sticky: a request with addr[1:0] != 0 was seen
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory WriteData
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_read_data  in  DATA_W  from ReadData

## Operation
- FSM states: BOOT, RUN, DRAIN.
- BOOT: fetch_gnt=0, cpu_hold=1; load_ready = load_valid; aligned grant drives mem_write=1, mem_address=load_addr, mem_write_data=load_data.
- BOOT -> DRAIN on load_done. Same-cycle load_valid is still accepted.
- DRAIN lasts one cycle: no grants, cpu_hold=1, flushes memory write settle. DRAIN -> RUN unconditionally.
- RUN: cpu_hold=0. Arbitration each cycle:
  - fetch_req only -> fetch.
  - load_valid only -> load.
  - both -> fetch, unless run_cnt == MAX_FETCH_RUN -> load.
- run_cnt (4-bit): increments on a fetch grant while load_valid=1. Clears on a load grant or when load_valid=0. Saturates at MAX_FETCH_RUN.
- Fetch grant: mem_read=1, mem_address=fetch_addr. mem_read_data is captured into fetch_data at the clock edge, and fetch_valid=1 in the following cycle.
- Only one of mem_read/mem_write is high in any cycle. Both are low when nothing is granted; mem_address then holds its last value.
- Misaligned request (addr[1:0] != 0):
  - Still granted; err_misaligned sets and stays set until reset.
  - Load: load_ready=1 but mem_write=0 (write dropped).
  - Fetch: mem_read=1 with the address forced to addr & ~3.
- load_done outside BOOT is ignored.

## Timing
- Reset values:
  - State BOOT, run_cnt 0.
  - fetch_data 0, fetch_valid 0, err_misaligned 0.
  - cpu_hold 1, load_ready 0, fetch_gnt 0, mem_read 0, mem_write 0.
  - mem_address 0, mem_write_data 0.
- load_ready, fetch_gnt, mem_* are combinational from state and requests: same-cycle accept.
- fetch_valid and fetch_data are registered; fetch latency is exactly 1 cycle after fetch_gnt. Back-to-back grants give back-to-back valids.
- fetch_valid falls in the cycle after a cycle without fetch_gnt; fetch_data holds its last value.
- Boot exit: load_done at cycle N -> DRAIN at N+1 -> RUN at N+2. The first possible fetch_gnt is at N+2.
- Reset asserted mid-operation: all outputs take their reset values asynchronously. An in-flight fetch_valid is dropped.
- Requesters hold address and data stable until granted.

## Structure
- Shared package (Defines.v) holds:
  - state encodings IMC_BOOT/IMC_DRAIN/IMC_RUN;
  - `INSTRUCTION_LEN` reuse;
  - MAX_FETCH_RUN default.
- Optional sub-module imc_rr_guard: the run_cnt counter plus the load-priority decision. Everything else is flat.

## Test plan
- Boot load: write 0xE3A00014 to addr 4 and 0xE3A01A01 to addr 8, pulse load_done. Expect:
  - fetch_gnt=0 throughout BOOT and DRAIN;
  - cpu_hold falls exactly 2 cycles after load_done;
  - fetch of addr 4 returns 0xE3A00014 with fetch_valid one cycle after the grant.
- Starvation bound (MAX_FETCH_RUN=4): fetch_req held high, load_valid raised at cycle T. Expect fetch grants at T..T+3, load_ready at T+4, then fetch resumes at T+5.
- Idle port: no requests in RUN. Expect mem_read=mem_write=0 and fetch_valid=0 one cycle later.
- Misaligned: load to addr 0x0A. Expect load_ready=1, mem_write=0, err_misaligned=1 and sticky. Fetch of 0x0E: mem_address=0x0C.
- Reset mid-fetch: assert rst low between fetch_gnt and the capture edge. Expect fetch_valid=0, cpu_hold=1, state BOOT immediately.
- load_done coincident with load_valid: the write is accepted. A later load_done in RUN causes no state change.

Source files
------------

// File: rtl/imem_access_ctrl_pkg.sv
// Shared definitions for the instruction-memory access controller.
// Holds the controller state encodings, the instruction word width and the
// default fetch-run bound used when a load is waiting.
package imem_access_ctrl_pkg;

  localparam int unsigned INSTRUCTION_LEN   = 32;
  localparam int unsigned IMC_ADDR_W        = 32;
  localparam int unsigned IMC_MAX_FETCH_RUN = 4;
  localparam int unsigned IMC_RUN_CNT_W     = 4;

  typedef enum logic [1:0] {
    IMC_BOOT  = 2'd0,
    IMC_DRAIN = 2'd1,
    IMC_RUN   = 2'd2
  } imc_state_e;

  // Word accesses only: the two byte-offset bits must be zero.
  function automatic logic imc_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/imem_access_ctrl_rr_guard.sv
// Loader starvation guard.
// Counts fetch grants issued while a load is waiting and raises
// load_prio_c once MAX_FETCH_RUN of them have been given back to back.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load_valid     loader request present
//   fetch_gnt      fetch granted this cycle
//   load_gnt       load granted this cycle
//   load_prio_c    loader wins the next conflict (combinational from count)
module imem_access_ctrl_rr_guard
  import imem_access_ctrl_pkg::*;
#(
  parameter int unsigned MAX_FETCH_RUN = IMC_MAX_FETCH_RUN
) (
  input  logic clk,
  input  logic rst,
  input  logic load_valid,
  input  logic fetch_gnt,
  input  logic load_gnt,
  output logic load_prio_c
);

  localparam logic [IMC_RUN_CNT_W-1:0] RUN_MAX = IMC_RUN_CNT_W'(MAX_FETCH_RUN);

  logic [IMC_RUN_CNT_W-1:0] run_cnt;

  // Run length of fetches that overtook a waiting load; saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (load_gnt || !load_valid) begin
      run_cnt <= '0;
    end else if (fetch_gnt && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign load_prio_c = (run_cnt == RUN_MAX);

endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory port sequencer and arbiter.
// Holds the core in BOOT while the loader fills memory, spends one DRAIN
// cycle after load_done, then shares the single memory port between fetch
// reads and loader writes with a bounded fetch run while a load waits.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   load_valid/addr/data, load_ready loader write request, same-cycle accept
//   load_done                        boot image complete (BOOT only)
//   fetch_req/addr, fetch_gnt        fetch read request, same-cycle grant
//   fetch_valid, fetch_data          registered read data, one cycle after grant
//   cpu_hold                         core stall outside RUN
//   err_misaligned                   sticky misaligned-request flag
//   mem_address/write_data/read/write, mem_read_data  memory port
module imem_access_ctrl
  import imem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W        = IMC_ADDR_W,
  parameter int unsigned DATA_W        = INSTRUCTION_LEN,
  parameter int unsigned MAX_FETCH_RUN = IMC_MAX_FETCH_RUN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_hold,
  output logic              err_misaligned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  imc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              load_prio_c;
  logic              load_ok_c;
  logic              fetch_ok_c;

  assign load_ok_c  = imc_aligned(load_addr[1:0]);
  assign fetch_ok_c = imc_aligned(fetch_addr[1:0]);

  imem_access_ctrl_rr_guard #(
    .MAX_FETCH_RUN (MAX_FETCH_RUN)
  ) u_rr_guard (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .fetch_gnt   (fetch_gnt),
    .load_gnt    (load_ready),
    .load_prio_c (load_prio_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IMC_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and same-cycle grants; gated by rst so reset forces all
  // grants low asynchronously.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    fetch_gnt  = 1'b0;
    if (rst) begin
      unique case (state_q)
        IMC_BOOT: begin
          load_ready = load_valid;
          if (load_done) begin
            state_d = IMC_DRAIN;
          end
        end
        IMC_DRAIN: begin
          state_d = IMC_RUN;
        end
        IMC_RUN: begin
          if (fetch_req && !(load_valid && load_prio_c)) begin
            fetch_gnt = 1'b1;
          end else if (load_valid) begin
            load_ready = 1'b1;
          end
        end
        default: begin
          state_d = IMC_BOOT;
        end
      endcase
    end
  end

  // Memory port drive; a misaligned load is acknowledged but never written.
  always_comb begin
    mem_read       = fetch_gnt;
    mem_write      = load_ready && load_ok_c;
    mem_address    = addr_q;
    mem_write_data = wdata_q;
    if (mem_read) begin
      mem_address = {fetch_addr[ADDR_W-1:2], 2'b00};
    end else if (mem_write) begin
      mem_address    = load_addr;
      mem_write_data = load_data;
    end
  end

  assign cpu_hold = (state_q != IMC_RUN);

  // Port hold values, fetch capture and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      fetch_valid    <= 1'b0;
      fetch_data     <= '0;
      err_misaligned <= 1'b0;
    end else begin
      addr_q      <= mem_address;
      wdata_q     <= mem_write_data;
      fetch_valid <= fetch_gnt;
      if (fetch_gnt) begin
        fetch_data <= mem_read_data;
      end
      if ((fetch_gnt && !fetch_ok_c) || (load_ready && !load_ok_c)) begin
        err_misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Randomised and directed bench for imem_access_ctrl with a byte-wide
// big-endian memory, a word-level reference model and a fetch scoreboard.
module tb_imem_access_ctrl;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        load_done = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        cpu_hold;
  logic        err_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  imem_access_ctrl #(
    .ADDR_W(32), .DATA_W(32), .MAX_FETCH_RUN(MAXR)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .cpu_hold(cpu_hold), .err_misaligned(err_misaligned),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Byte-organised big-endian memory with combinational read.
  logic [7:0] bytes [0:255];
  logic [7:0] ma;
  assign ma = mem_address[7:0];
  assign mem_read_data = {bytes[ma], bytes[ma + 8'd1], bytes[ma + 8'd2], bytes[ma + 8'd3]};
  always @(posedge clk) begin
    if (mem_write) begin
      bytes[ma]        <= mem_write_data[31:24];
      bytes[ma + 8'd1] <= mem_write_data[23:16];
      bytes[ma + 8'd2] <= mem_write_data[15:8];
      bytes[ma + 8'd3] <= mem_write_data[7:0];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=boot,1=drain,2=run; fetches that overtook a waiting load.
  int          phase;
  int          overtakes;
  bit          m_err;
  logic [31:0] m_last_addr;
  logic [31:0] ref_mem [int];
  logic [31:0] sbq [$];
  bit          e_lr, e_fg;

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic model_reset();
    phase = 0; overtakes = 0; m_err = 1'b0; m_last_addr = '0;
    sbq.delete();
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model.
  task automatic cycle(input bit lv, input logic [31:0] la, input logic [31:0] ld,
                       input bit ldn, input bit fr, input logic [31:0] fa);
    bit          e_wr, load_turn;
    logic [31:0] e_addr;
    @(negedge clk);
    load_valid = lv; load_addr = la; load_data = ld; load_done = ldn;
    fetch_req = fr; fetch_addr = fa;
    #1;
    e_lr = 1'b0; e_fg = 1'b0;
    if (phase == 0) begin
      e_lr = lv;
    end else if (phase == 2) begin
      load_turn = lv && (!fr || overtakes >= MAXR);
      e_fg = fr && !load_turn;
      e_lr = load_turn;
    end
    e_wr   = e_lr && (la[1:0] == 2'b00);
    e_addr = e_fg ? (fa & ~32'd3) : (e_wr ? la : m_last_addr);
    chk("cpu_hold", 32'(cpu_hold), 32'(phase != 2));
    chk("load_ready", 32'(load_ready), 32'(e_lr));
    chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
    chk("mem_read", 32'(mem_read), 32'(e_fg));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("mem_address", mem_address, e_addr);
    if (e_wr) chk("mem_write_data", mem_write_data, ld);
    chk("err_misaligned", 32'(err_misaligned), 32'(m_err));
    if (e_fg) sbq.push_back(ref_rd(int'(fa >> 2)));
    if (e_wr) ref_mem[int'(la >> 2)] = ld;
    if ((e_lr && la[1:0] != 2'b00) || (e_fg && fa[1:0] != 2'b00)) m_err = 1'b1;
    m_last_addr = e_addr;
    if (e_lr || !lv) overtakes = 0;
    else if (e_fg && overtakes < MAXR) overtakes++;
    if (phase == 0 && ldn) phase = 1;
    else if (phase == 1) phase = 2;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Fetch scoreboard: every grant must yield exactly one valid word next cycle.
  logic [31:0] sb_exp;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("fetch_valid", 32'(fetch_valid), 32'(sbq.size() != 0));
      if (sbq.size() != 0) begin
        sb_exp = sbq.pop_front();
        chk("fetch_data", fetch_data, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [5:0]  fgbits, lrbits;
  bit          pl, pf;
  logic [31:0] rla, rld, rfa, boot2;

  initial begin
    for (int i = 0; i < 256; i++) bytes[i] = 8'h00;
    model_reset();
    load_valid = 1'b1;
    #1;
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data", fetch_data, 32'd0);
    chk("rst_err", 32'(err_misaligned), 32'd0);
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Boot load; fetch requests are ignored until RUN.
    cycle(1'b1, 32'd4, 32'hE3A00014, 1'b0, 1'b1, 32'd4);
    chk("boot_no_fetch", 32'(fetch_gnt), 32'd0);
    cycle(1'b1, 32'd8, 32'hE3A01A01, 1'b0, 1'b1, 32'd4);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd4);
    chk("boot_hold_n", 32'(cpu_hold), 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd4);
    chk("drain_hold", 32'(cpu_hold), 32'd1);
    chk("drain_no_fetch", 32'(fetch_gnt), 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd4);
    chk("run_hold_n2", 32'(cpu_hold), 32'd0);
    chk("run_first_gnt", 32'(fetch_gnt), 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8);
    chk("boot_word4_valid", 32'(fetch_valid), 32'd1);
    chk("boot_word4", fetch_data, 32'hE3A00014);
    idle();
    chk("boot_word8", fetch_data, 32'hE3A01A01);
    idle();
    chk("idle_valid_low", 32'(fetch_valid), 32'd0);
    chk("idle_mem_read", 32'(mem_read), 32'd0);
    chk("idle_mem_write", 32'(mem_write), 32'd0);

    // Starvation bound: loader raised at T, wins at T+MAXR.
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h7C);
    for (int i = 0; i < 6; i++) begin
      cycle(i <= 4, 32'h40, 32'h1234_5678, 1'b0, 1'b1, 32'h80 + 32'(4 * i));
      fgbits[i] = fetch_gnt;
      lrbits[i] = load_ready;
    end
    chk("starve_fetch_gnt", 32'(fgbits), 32'(6'b101111));
    chk("starve_load_ready", 32'(lrbits), 32'(6'b010000));

    // Misaligned load and fetch.
    cycle(1'b1, 32'h0A, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk("mis_load_ready", 32'(load_ready), 32'd1);
    chk("mis_load_nowrite", 32'(mem_write), 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0E);
    chk("mis_err_set", 32'(err_misaligned), 32'd1);
    chk("mis_fetch_addr", mem_address, 32'h0C);
    idle();
    idle();
    chk("mis_err_sticky", 32'(err_misaligned), 32'd1);

    // Random traffic; requesters hold until the model says they were granted.
    pl = 1'b0; pf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pl && $urandom_range(0, 2) == 0) begin
        pl = 1'b1;
        rla = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) rla[1:0] = 2'b00;
        rld = $urandom;
      end
      if (!pf && $urandom_range(0, 3) != 0) begin
        pf = 1'b1;
        rfa = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) rfa[1:0] = 2'b00;
      end
      cycle(pl, rla, rld, $urandom_range(0, 49) == 0, pf, rfa);
      if (e_lr) pl = 1'b0;
      if (e_fg) pf = 1'b0;
    end
    idle();

    // Reset between a fetch grant and its capture edge.
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h10);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h14);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rstmid_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rstmid_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rstmid_fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("rstmid_mem_read", 32'(mem_read), 32'd0);
    chk("rstmid_err", 32'(err_misaligned), 32'd0);
    chk("rstmid_mem_address", mem_address, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // load_done together with a write; later load_done in RUN is ignored.
    boot2 = $urandom;
    cycle(1'b1, 32'h20, boot2, 1'b1, 1'b1, 32'h20);
    chk("done_coinc_ready", 32'(load_ready), 32'd1);
    chk("done_coinc_write", 32'(mem_write), 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h20);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h20);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0);
    chk("done_coinc_data", fetch_data, boot2);
    idle();
    chk("done_in_run_hold", 32'(cpu_hold), 32'd0);
    idle();
    idle();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
